lock_sequence_controller: RTL and testbench

//  Clocked sequencer for the digital lock. Conditions the raw KEY inputs and

---
 rtl/lock_pkg.sv | 15 +
 rtl/button_conditioner.sv | 52 +++++
 rtl/lock_sequence_controller.sv | 154 +++++++++++++++
 tb/tb_lock_sequence_controller.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared state definitions for the lock sequencer and the HEX display driver.
package lock_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 4'd0,
        ENTRY   = 4'd1,
        CHECK   = 4'd2,
        OPEN    = 4'd3,
        PROGRAM = 4'd4,
        LOCKOUT = 4'd5
    } lock_state_t;

endpackage

// File: rtl/button_conditioner.sv
// Conditions one active-low push button: synchronise, debounce, and emit a
// single-cycle pulse when the debounced level goes from released to pressed.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic Btn_n,
    output logic Pressed
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

    logic             sync1;
    logic             sync2;
    logic             stable_n;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser; resets to the released level.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= Btn_n;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it differs from the stable one for
    // DEBOUNCE_CYCLES consecutive cycles; pulse on the accepted press edge.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt      <= '0;
            stable_n <= 1'b1;
            Pressed  <= 1'b0;
        end else begin
            Pressed <= 1'b0;
            if (sync2 == stable_n) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt      <= '0;
                stable_n <= sync2;
                Pressed  <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lock_sequence_controller.sv
// Digital lock sequencer: serial code entry, compare against a
// reprogrammable stored code, failure counting and timed lockout.
module lock_sequence_controller
    import lock_pkg::*;
#(
    parameter int                  CODE_LEN        = 7,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE    = 7'b1110111,
    parameter int                  MAX_FAILS       = 3,
    parameter int                  LOCKOUT_CYCLES  = 50_000_000,
    parameter int                  DEBOUNCE_CYCLES = 500_000
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               X,
    input  logic               Enter_n,
    input  logic               Lock_n,
    input  logic               Program,
    output logic               Open,
    output logic               LockedOut,
    output logic [STATE_W-1:0] State,
    output logic [2:0]         BitCount,
    output logic [1:0]         FailCount
);

    localparam int TMR_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]       LAST_BIT = 3'(CODE_LEN - 1);

    lock_state_t         state;
    logic [CODE_LEN-1:0] code_sr;
    logic [CODE_LEN-1:0] stored;
    logic [CODE_LEN-1:0] shifted;
    logic [TMR_W-1:0]    timer;
    logic                enter_p;
    logic                lock_p;
    logic                last_bit;
    logic                fail_limit;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Btn_n   (Enter_n),
        .Pressed (enter_p)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lock (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Btn_n   (Lock_n),
        .Pressed (lock_p)
    );

    // First bit entered drifts up to the MSB as later bits arrive.
    assign shifted    = {code_sr[CODE_LEN-2:0], X};
    assign last_bit   = (BitCount == LAST_BIT);
    assign fail_limit = ((int'(FailCount) + 1) == MAX_FAILS);
    assign State      = state;

    // Sequencer FSM with its datapath registers; Lock is checked before
    // Enter everywhere so a simultaneous press resolves to Lock.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            code_sr   <= '0;
            stored    <= DEFAULT_CODE;
            BitCount  <= '0;
            FailCount <= '0;
            timer     <= '0;
            Open      <= 1'b0;
            LockedOut <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!lock_p && enter_p) begin
                        code_sr  <= shifted;
                        BitCount <= 3'd1;
                        state    <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (lock_p) begin
                        code_sr  <= '0;
                        BitCount <= '0;
                        state    <= IDLE;
                    end else if (enter_p) begin
                        code_sr  <= shifted;
                        BitCount <= BitCount + 3'd1;
                        if (last_bit) state <= CHECK;
                    end
                end
                CHECK: begin
                    BitCount <= '0;
                    if (code_sr == stored) begin
                        FailCount <= '0;
                        Open      <= 1'b1;
                        state     <= OPEN;
                    end else if (fail_limit) begin
                        timer     <= TMR_LOAD;
                        LockedOut <= 1'b1;
                        state     <= LOCKOUT;
                    end else begin
                        FailCount <= FailCount + 2'd1;
                        state     <= IDLE;
                    end
                end
                OPEN: begin
                    if (lock_p) begin
                        Open  <= 1'b0;
                        state <= IDLE;
                    end else if (enter_p && Program) begin
                        code_sr <= '0;
                        Open    <= 1'b0;
                        state   <= PROGRAM;
                    end
                end
                PROGRAM: begin
                    if (lock_p) begin
                        code_sr  <= '0;
                        BitCount <= '0;
                        Open     <= 1'b1;
                        state    <= OPEN;
                    end else if (enter_p) begin
                        code_sr <= shifted;
                        if (last_bit) begin
                            stored   <= shifted;
                            BitCount <= '0;
                            Open     <= 1'b1;
                            state    <= OPEN;
                        end else begin
                            BitCount <= BitCount + 3'd1;
                        end
                    end
                end
                LOCKOUT: begin
                    if (timer == '0) begin
                        FailCount <= '0;
                        LockedOut <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    code_sr   <= '0;
                    BitCount  <= '0;
                    Open      <= 1'b0;
                    LockedOut <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_sequence_controller.sv
// Scenario bench for the lock sequencer with short debounce and lockout.
module tb_lock_sequence_controller;

    localparam int HOLD = 5;
    localparam int GAP  = 5;

    logic       Clock;
    logic       Reset_n;
    logic       X;
    logic       Enter_n;
    logic       Lock_n;
    logic       Program;
    logic       Open;
    logic       LockedOut;
    logic [3:0] State;
    logic [2:0] BitCount;
    logic [1:0] FailCount;

    int tests = 0;
    int fails = 0;

    // attempt-level reference model
    logic [6:0] model_code;
    int         model_fails;

    // passive observers
    logic [3:0] prev_state = 4'd0;
    int         check_events = 0;
    logic [3:0] post_state = 4'd0;
    logic       post_open = 1'b0;
    logic       check_open = 1'b0;
    int         lock_cycles = 0;
    int         lock_mismatch = 0;

    lock_sequence_controller #(
        .DEBOUNCE_CYCLES (2),
        .LOCKOUT_CYCLES  (20)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .X         (X),
        .Enter_n   (Enter_n),
        .Lock_n    (Lock_n),
        .Program   (Program),
        .Open      (Open),
        .LockedOut (LockedOut),
        .State     (State),
        .BitCount  (BitCount),
        .FailCount (FailCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (prev_state == 4'd2) begin
            check_events++;
            post_state = State;
            post_open  = Open;
        end
        if (State == 4'd2) check_open = Open;
        if (State == 4'd5 && LockedOut) lock_cycles++;
        if (Reset_n && ((State == 4'd5) != LockedOut)) lock_mismatch++;
        prev_state = State;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic press_enter(input logic b);
        @(posedge Clock); #1;
        X = b; Enter_n = 1'b0;
        repeat (HOLD) @(posedge Clock);
        #1 Enter_n = 1'b1;
        repeat (GAP) @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic press_lock();
        @(posedge Clock); #1;
        Lock_n = 1'b0;
        repeat (HOLD) @(posedge Clock);
        #1 Lock_n = 1'b1;
        repeat (GAP) @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic press_both(input logic b);
        @(posedge Clock); #1;
        X = b; Enter_n = 1'b0; Lock_n = 1'b0;
        repeat (HOLD) @(posedge Clock);
        #1 Enter_n = 1'b1; Lock_n = 1'b1;
        repeat (GAP) @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic enter_code(input logic [6:0] c);
        for (int i = 6; i >= 0; i--) press_enter(c[i]);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock);
            if (State == 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_reset();
        repeat (2) @(posedge Clock);
        #1 Reset_n = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        model_code  = 7'b1110111;
        model_fails = 0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; X = 1'b0; Enter_n = 1'b1; Lock_n = 1'b1; Program = 1'b0;
        repeat (3) @(negedge Clock);
        tests++; if (State !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", State); end
        tests++; if (Open !== 1'b0) begin fails++; $display("FAIL reset_open: got %b want 0", Open); end
        tests++; if (LockedOut !== 1'b0) begin fails++; $display("FAIL reset_lockedout: got %b want 0", LockedOut); end
        tests++; if (BitCount !== 3'd0) begin fails++; $display("FAIL reset_bitcount: got %0d want 0", BitCount); end
        tests++; if (FailCount !== 2'd0) begin fails++; $display("FAIL reset_failcount: got %0d want 0", FailCount); end
        release_reset();
    endtask

    task automatic test_open_close();
        logic [6:0] c;
        int ce;
        c = model_code;
        for (int i = 6; i >= 1; i--) begin
            press_enter(c[i]);
            tests++;
            if (State !== 4'd1 || BitCount !== 3'(7 - i)) begin
                fails++; $display("FAIL t1_entry_bit%0d: state %0d count %0d want 1 %0d", 7 - i, State, BitCount, 7 - i);
            end
        end
        ce = check_events;
        press_enter(c[0]);
        tests++; if (check_events !== ce + 1) begin fails++; $display("FAIL t1_check_once: got %0d events want 1", check_events - ce); end
        tests++; if (check_open !== 1'b0) begin fails++; $display("FAIL t1_open_in_check: got %b want 0", check_open); end
        tests++; if (post_state !== 4'd3 || post_open !== 1'b1) begin fails++; $display("FAIL t1_after_check: state %0d open %b want 3 1", post_state, post_open); end
        tests++; if (State !== 4'd3 || Open !== 1'b1) begin fails++; $display("FAIL t1_open: state %0d open %b want 3 1", State, Open); end
        press_lock();
        tests++; if (State !== 4'd0 || Open !== 1'b0) begin fails++; $display("FAIL t1_lock: state %0d open %b want 0 0", State, Open); end
    endtask

    task automatic test_lockout();
        logic [6:0] bad;
        bit ok;
        bad = 7'b1110110;
        for (int a = 1; a <= 2; a++) begin
            enter_code(bad);
            model_fails++;
            tests++;
            if (State !== 4'd0 || FailCount !== 2'(model_fails)) begin
                fails++; $display("FAIL t2_fail%0d: state %0d fails %0d want 0 %0d", a, State, FailCount, model_fails);
            end
        end
        lock_cycles = 0;
        enter_code(bad);
        tests++; if (State !== 4'd5 || LockedOut !== 1'b1) begin fails++; $display("FAIL t2_enter_lockout: state %0d locked %b want 5 1", State, LockedOut); end
        press_enter(1'b1);
        tests++; if (State !== 4'd5 || BitCount !== 3'd0) begin fails++; $display("FAIL t2_enter_ignored: state %0d count %0d want 5 0", State, BitCount); end
        wait_idle(ok);
        model_fails = 0;
        tests++; if (!ok) begin fails++; $display("FAIL t2_timeout: state %0d want 0", State); end
        @(negedge Clock);
        tests++; if (lock_cycles !== 20) begin fails++; $display("FAIL t2_lock_len: got %0d cycles want 20", lock_cycles); end
        tests++; if (FailCount !== 2'd0 || LockedOut !== 1'b0) begin fails++; $display("FAIL t2_after: fails %0d locked %b want 0 0", FailCount, LockedOut); end
    endtask

    task automatic test_debounce();
        @(posedge Clock); #1 X = 1'b1; Enter_n = 1'b0;
        @(posedge Clock); #1 Enter_n = 1'b1;
        repeat (10) @(posedge Clock);
        @(negedge Clock);
        tests++; if (State !== 4'd0 || BitCount !== 3'd0) begin fails++; $display("FAIL t3_glitch: state %0d count %0d want 0 0", State, BitCount); end
        @(posedge Clock); #1 X = 1'b1; Enter_n = 1'b0;
        repeat (100) @(posedge Clock);
        #1 Enter_n = 1'b1;
        repeat (10) @(posedge Clock);
        @(negedge Clock);
        tests++; if (State !== 4'd1 || BitCount !== 3'd1) begin fails++; $display("FAIL t3_held: state %0d count %0d want 1 1", State, BitCount); end
        press_lock();
        tests++; if (State !== 4'd0 || BitCount !== 3'd0) begin fails++; $display("FAIL t3_abort: state %0d count %0d want 0 0", State, BitCount); end
    endtask

    task automatic test_program();
        logic [6:0] nc;
        nc = 7'b0101010;
        enter_code(model_code);
        tests++; if (State !== 4'd3) begin fails++; $display("FAIL t4_open: state %0d want 3", State); end
        Program = 1'b1;
        press_enter(1'b1);
        tests++; if (State !== 4'd4 || Open !== 1'b0 || BitCount !== 3'd0) begin fails++; $display("FAIL t4_prog_entry: state %0d open %b count %0d want 4 0 0", State, Open, BitCount); end
        for (int i = 6; i >= 1; i--) press_enter(nc[i]);
        tests++; if (State !== 4'd4 || BitCount !== 3'd6 || Open !== 1'b0) begin fails++; $display("FAIL t4_prog_bits: state %0d count %0d open %b want 4 6 0", State, BitCount, Open); end
        press_enter(nc[0]);
        model_code = nc;
        tests++; if (State !== 4'd3 || Open !== 1'b1) begin fails++; $display("FAIL t4_prog_done: state %0d open %b want 3 1", State, Open); end
        Program = 1'b0;
        press_lock();
        enter_code(nc);
        tests++; if (State !== 4'd3 || Open !== 1'b1) begin fails++; $display("FAIL t4_new_code: state %0d open %b want 3 1", State, Open); end
        press_lock();
        enter_code(7'b1110111);
        model_fails++;
        tests++; if (State !== 4'd0 || FailCount !== 2'(model_fails)) begin fails++; $display("FAIL t4_old_code: state %0d fails %0d want 0 %0d", State, FailCount, model_fails); end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 4; i++) press_enter(1'($urandom_range(0, 1)));
        tests++; if (State !== 4'd1 || BitCount !== 3'd4) begin fails++; $display("FAIL t5_four_bits: state %0d count %0d want 1 4", State, BitCount); end
        press_lock();
        tests++; if (State !== 4'd0 || BitCount !== 3'd0 || FailCount !== 2'(model_fails)) begin fails++; $display("FAIL t5_abort: state %0d count %0d fails %0d want 0 0 %0d", State, BitCount, FailCount, model_fails); end
        press_enter(1'b1);
        press_enter(1'b0);
        press_both(1'b1);
        tests++; if (State !== 4'd0 || BitCount !== 3'd0) begin fails++; $display("FAIL t5_both_entry: state %0d count %0d want 0 0", State, BitCount); end
        press_both(1'b1);
        tests++; if (State !== 4'd0 || BitCount !== 3'd0) begin fails++; $display("FAIL t5_both_idle: state %0d count %0d want 0 0", State, BitCount); end
    endtask

    task automatic test_random();
        logic [6:0] c;
        logic [3:0] exp_state;
        bit ok;
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                int k;
                k = $urandom_range(1, 6);
                for (int j = 0; j < k; j++) press_enter(1'($urandom_range(0, 1)));
                press_lock();
                tests++; if (State !== 4'd0 || BitCount !== 3'd0 || FailCount !== 2'(model_fails)) begin fails++; $display("FAIL rnd_abort%0d: state %0d count %0d fails %0d want 0 0 %0d", it, State, BitCount, FailCount, model_fails); end
            end
            c = ($urandom_range(0, 1) == 1) ? model_code : 7'($urandom_range(0, 127));
            enter_code(c);
            if (c == model_code) begin
                exp_state = 4'd3; model_fails = 0;
            end else if (model_fails + 1 == 3) begin
                exp_state = 4'd5;
            end else begin
                exp_state = 4'd0; model_fails++;
            end
            tests++;
            if (State !== exp_state || Open !== (exp_state == 4'd3) || LockedOut !== (exp_state == 4'd5)) begin
                fails++; $display("FAIL rnd_attempt%0d: state %0d open %b locked %b want %0d", it, State, Open, LockedOut, exp_state);
            end
            if (exp_state != 4'd5) begin
                tests++; if (FailCount !== 2'(model_fails)) begin fails++; $display("FAIL rnd_fails%0d: got %0d want %0d", it, FailCount, model_fails); end
            end
            if (exp_state == 4'd5) begin
                wait_idle(ok);
                model_fails = 0;
                tests++; if (!ok || FailCount !== 2'd0) begin fails++; $display("FAIL rnd_lockout%0d: state %0d fails %0d want 0 0", it, State, FailCount); end
            end
            if (exp_state == 4'd3) begin
                press_lock();
                tests++; if (State !== 4'd0) begin fails++; $display("FAIL rnd_close%0d: state %0d want 0", it, State); end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] bad;
        bad = ~model_code;
        // mid-OPEN
        enter_code(model_code);
        @(posedge Clock); #3 Reset_n = 1'b0; #1;
        tests++; if (State !== 4'd0 || Open !== 1'b0 || LockedOut !== 1'b0) begin fails++; $display("FAIL t6_rst_open: state %0d open %b locked %b want 0 0 0", State, Open, LockedOut); end
        release_reset();
        // mid-PROGRAM, after a new code was already stored
        enter_code(model_code);
        Program = 1'b1;
        press_enter(1'b0);
        enter_code(7'b0101010);
        press_enter(1'b0);
        for (int i = 0; i < 3; i++) press_enter(1'b1);
        tests++; if (State !== 4'd4) begin fails++; $display("FAIL t6_in_program: state %0d want 4", State); end
        @(posedge Clock); #3 Reset_n = 1'b0; #1;
        tests++; if (State !== 4'd0 || Open !== 1'b0 || LockedOut !== 1'b0) begin fails++; $display("FAIL t6_rst_prog: state %0d open %b locked %b want 0 0 0", State, Open, LockedOut); end
        Program = 1'b0;
        release_reset();
        enter_code(7'b1110111);
        tests++; if (State !== 4'd3 || Open !== 1'b1) begin fails++; $display("FAIL t6_default_code: state %0d open %b want 3 1", State, Open); end
        press_lock();
        // mid-LOCKOUT
        for (int a = 0; a < 3; a++) enter_code(bad);
        tests++; if (State !== 4'd5) begin fails++; $display("FAIL t6_in_lockout: state %0d want 5", State); end
        @(posedge Clock); #3 Reset_n = 1'b0; #1;
        tests++; if (State !== 4'd0 || LockedOut !== 1'b0 || FailCount !== 2'd0) begin fails++; $display("FAIL t6_rst_lockout: state %0d locked %b fails %0d want 0 0 0", State, LockedOut, FailCount); end
        release_reset();
        enter_code(model_code);
        tests++; if (State !== 4'd3) begin fails++; $display("FAIL t6_after_lockout: state %0d want 3", State); end
        press_lock();
        tests++; if (lock_mismatch !== 0) begin fails++; $display("FAIL lockedout_vs_state: %0d cycles disagreed want 0", lock_mismatch); end
    endtask

    initial begin
        model_code  = 7'b1110111;
        model_fails = 0;
        test_reset();
        test_open_close();
        test_lockout();
        test_debounce();
        test_program();
        test_abort();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
